// File: rtl/hazard_pkg.sv
// Opcode map and opcode-class decode shared by the hazard controller and its scoreboard.
// Latency: pure functions, no state.
// Backpressure: none; the classes only feed the stall/redirect decisions upstream.
package hazard_pkg;

    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_NOP   = 6'd0;
    localparam logic [OPC_W-1:0] OP_ADD   = 6'd1;
    localparam logic [OPC_W-1:0] OP_SUB   = 6'd2;
    localparam logic [OPC_W-1:0] OP_LOAD  = 6'd4;
    localparam logic [OPC_W-1:0] OP_MOVE  = 6'd5;
    localparam logic [OPC_W-1:0] OP_MOVEI = 6'd16;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'd19;
    localparam logic [OPC_W-1:0] OP_BRA   = 6'd21;
    localparam logic [OPC_W-1:0] OP_JUMP  = 6'd22;

    // Opcodes that produce a register result.
    function automatic logic is_writer(input logic [OPC_W-1:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB) ||
               ((opc >= OP_LOAD) && (opc <= 6'd20));
    endfunction

    // Immediate-format writers put their destination in the RS2 field.
    function automatic logic dst_is_rs2(input logic [OPC_W-1:0] opc);
        return (opc == OP_LOAD) || (opc == OP_MOVE) ||
               ((opc >= 6'd15) && (opc <= 6'd20));
    endfunction

    function automatic logic reads_rs1(input logic [OPC_W-1:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_LOAD) ||
               ((opc >= 6'd6) && (opc <= 6'd15)) ||
               ((opc >= 6'd17) && (opc <= OP_BRA));
    endfunction

    function automatic logic reads_rs2(input logic [OPC_W-1:0] opc);
        return (opc == OP_ADD) || (opc == OP_SUB) ||
               ((opc >= 6'd6) && (opc <= 6'd14));
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-deep shift register of in-flight writes (ALU, DM, WB) plus source-match logic.
// Latency: match is combinational on current entries; the issued entry lands in ALU slot next edge.
// Backpressure: none; the caller inserts an empty entry whenever it stalls or squashes.
// Ports: clk, reset (sync, active-high); issue_v/issue_dst = entry entering ALU slot;
//        rs1/rs2 with rs1_en/rs2_en = sources actually read; match = a pending write hits a source.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG_BITS = 5,
    parameter int WB_BYPASS = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_v,
    input  logic [NREG_BITS-1:0] issue_dst,
    input  logic [NREG_BITS-1:0] rs1,
    input  logic [NREG_BITS-1:0] rs2,
    input  logic                 rs1_en,
    input  logic                 rs2_en,
    output logic                 match
);

    logic                 alu_v_q, alu_v_d, dm_v_q, dm_v_d, wb_v_q, wb_v_d;
    logic [NREG_BITS-1:0] alu_dst_q, alu_dst_d, dm_dst_q, dm_dst_d, wb_dst_q, wb_dst_d;
    logic                 hit_alu, hit_dm, hit_wb;

    always_comb begin
        alu_v_d   = issue_v;
        alu_dst_d = issue_dst;
        dm_v_d    = alu_v_q;
        dm_dst_d  = alu_dst_q;
        wb_v_d    = dm_v_q;
        wb_dst_d  = dm_dst_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_v_q   <= 1'b0;
            dm_v_q    <= 1'b0;
            wb_v_q    <= 1'b0;
            alu_dst_q <= '0;
            dm_dst_q  <= '0;
            wb_dst_q  <= '0;
        end else begin
            alu_v_q   <= alu_v_d;
            dm_v_q    <= dm_v_d;
            wb_v_q    <= wb_v_d;
            alu_dst_q <= alu_dst_d;
            dm_dst_q  <= dm_dst_d;
            wb_dst_q  <= wb_dst_d;
        end
    end

    always_comb begin
        hit_alu = alu_v_q && ((rs1_en && (rs1 == alu_dst_q)) || (rs2_en && (rs2 == alu_dst_q)));
        hit_dm  = dm_v_q  && ((rs1_en && (rs1 == dm_dst_q))  || (rs2_en && (rs2 == dm_dst_q)));
        hit_wb  = wb_v_q  && ((rs1_en && (rs1 == wb_dst_q))  || (rs2_en && (rs2 == wb_dst_q)));
        // A write-before-read register file makes the WB-stage write visible in time.
        match   = hit_alu || hit_dm || ((WB_BYPASS == 0) && hit_wb);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RAW interlock and branch/jump flush controller for the 5-stage pipeline, with perf counters.
// Latency: hold/bubble/redirect are combinational; squash starts the cycle after a redirect.
// Backpressure: a hazard freezes PC and RF stage and bubbles ALU until the pending write retires.
// Ports: clk, reset (sync, active-high); rf_valid/rf_opc/rf_rs1/rf_rs2/rf_rd = RF-stage instruction;
//        br_eq = branch compare; pc_hold/rf_hold/alu_bubble = stall; rf_squash, redirect = flush;
//        stall_cnt/flush_cnt = saturating counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREG_BITS   = 5,
    parameter int FLUSH_SLOTS = 1,
    parameter int WB_BYPASS   = 0,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rf_valid,
    input  logic [OPC_W-1:0]     rf_opc,
    input  logic [NREG_BITS-1:0] rf_rs1,
    input  logic [NREG_BITS-1:0] rf_rs2,
    input  logic [NREG_BITS-1:0] rf_rd,
    input  logic                 br_eq,
    output logic                 pc_hold,
    output logic                 rf_hold,
    output logic                 alu_bubble,
    output logic                 rf_squash,
    output logic                 redirect,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    logic [1:0]           sq_cnt_q, sq_cnt_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic                 eff_valid, hazard, sb_match, issue_v;
    logic [NREG_BITS-1:0] issue_dst;

    hazard_scoreboard #(
        .NREG_BITS (NREG_BITS),
        .WB_BYPASS (WB_BYPASS)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .issue_v   (issue_v),
        .issue_dst (issue_dst),
        .rs1       (rf_rs1),
        .rs2       (rf_rs2),
        .rs1_en    (reads_rs1(rf_opc)),
        .rs2_en    (reads_rs2(rf_opc)),
        .match     (sb_match)
    );

    always_comb begin
        // Priority: squash masks everything, hazard masks redirect.
        rf_squash = (sq_cnt_q != 2'd0);
        eff_valid = rf_valid && !rf_squash;
        hazard    = eff_valid && sb_match;
        redirect  = eff_valid && !hazard &&
                    ((rf_opc == OP_JUMP) || ((rf_opc == OP_BRA) && br_eq));
        issue_v   = eff_valid && !hazard && is_writer(rf_opc);
        issue_dst = dst_is_rs2(rf_opc) ? rf_rs2 : rf_rd;

        pc_hold    = hazard;
        rf_hold    = hazard;
        alu_bubble = hazard;

        if (redirect)
            sq_cnt_d = 2'(FLUSH_SLOTS);
        else if (rf_squash)
            sq_cnt_d = sq_cnt_q - 2'd1;
        else
            sq_cnt_d = sq_cnt_q;

        stall_cnt_d = (hazard && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (rf_squash && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sq_cnt_q    <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sq_cnt_q    <= sq_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, saturation sequence, random vs model.
// Latency: inputs driven 1ns after posedge, outputs compared at negedge.
// Backpressure: stimulus re-presents the RF instruction while the model predicts a hazard.
module tb_pipeline_hazard_ctrl;

    localparam int NB    = 5;
    localparam int FS    = 2;
    localparam int WBB   = 0;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          rf_valid;
    logic [5:0]    rf_opc;
    logic [NB-1:0] rf_rs1, rf_rs2, rf_rd;
    logic          br_eq;
    logic          pc_hold, rf_hold, alu_bubble, rf_squash, redirect;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .NREG_BITS   (NB),
        .FLUSH_SLOTS (FS),
        .WB_BYPASS   (WBB),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rf_valid   (rf_valid),
        .rf_opc     (rf_opc),
        .rf_rs1     (rf_rs1),
        .rf_rs2     (rf_rs2),
        .rf_rd      (rf_rd),
        .br_eq      (br_eq),
        .pc_hold    (pc_hold),
        .rf_hold    (rf_hold),
        .alu_bubble (alu_bubble),
        .rf_squash  (rf_squash),
        .redirect   (redirect),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    typedef struct {
        bit rst; bit vld; int opc; int rs1; int rs2; int rd; bit beq;
        bit haz; bit red; bit sq; int scnt; int fcnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit vld, int opc, int rs1, int rs2, int rd, bit beq,
                                bit haz, bit red, bit sq, int scnt, int fcnt);
        vec_t v;
        v.rst = rst; v.vld = vld; v.opc = opc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.beq = beq;
        v.haz = haz; v.red = red; v.sq = sq; v.scnt = scnt; v.fcnt = fcnt;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(bit rst, bit vld, int opc, int rs1, int rs2, int rd, bit beq);
        reset    = rst;
        rf_valid = vld;
        rf_opc   = 6'(opc);
        rf_rs1   = NB'(rs1);
        rf_rs2   = NB'(rs2);
        rf_rd    = NB'(rd);
        br_eq    = beq;
    endtask

    task automatic check_all(string tag, bit haz, bit red, bit sq, int scnt, int fcnt);
        chk({tag, " hold"},   int'({pc_hold, rf_hold, alu_bubble}), haz ? 7 : 0);
        chk({tag, " redir"},  int'(redirect), int'(red));
        chk({tag, " squash"}, int'(rf_squash), int'(sq));
        chk({tag, " stall"},  int'(stall_cnt), scnt);
        chk({tag, " flush"},  int'(flush_cnt), fcnt);
    endtask

    // Behavioural reference model: opcode classes straight from the opcode table,
    // in-flight writes as a list of the last three issued destinations (-1 = none).
    int  pend[$];
    int  m_sq_rem, m_scnt, m_fcnt;

    function automatic bit m_writer(int o); return o inside {1, 2, [4:20]}; endfunction
    function automatic bit m_rd1(int o);    return o inside {1, 2, 4, [6:15], [17:21]}; endfunction
    function automatic bit m_rd2(int o);    return o inside {1, 2, [6:14]}; endfunction
    function automatic int m_dst(int o, int rs2, int rd);
        return (o inside {4, 5, [15:20]}) ? rs2 : rd;
    endfunction

    task automatic model_reset();
        pend = '{-1, -1, -1};
        m_sq_rem = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    initial begin
        int cur_opc, cur_rs1, cur_rs2, cur_rd;
        bit cur_vld, cur_beq, cur_rst;
        int opc_pool[13] = '{0, 1, 2, 4, 5, 6, 15, 16, 19, 21, 22, 3, 40};
        int sat_stalls;

        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        // rst vld opc rs1 rs2 rd beq | haz red sq stall flush
        tbl.push_back(mk(0,1, 0, 0,0,0, 0, 0,0,0, 0,0));  // reset state
        tbl.push_back(mk(0,1, 1, 1,2,3, 0, 0,0,0, 0,0));  // ADD r3
        tbl.push_back(mk(0,1, 1, 3,5,4, 0, 1,0,0, 0,0));  // ADD reads r3: stall x3
        tbl.push_back(mk(0,1, 1, 3,5,4, 0, 1,0,0, 1,0));
        tbl.push_back(mk(0,1, 1, 3,5,4, 0, 1,0,0, 2,0));
        tbl.push_back(mk(0,1, 1, 3,5,4, 0, 0,0,0, 3,0));
        tbl.push_back(mk(0,1, 0, 0,0,0, 0, 0,0,0, 3,0));
        tbl.push_back(mk(0,1,19, 0,7,9, 0, 0,0,0, 3,0));  // ADDI dst=rs2=r7
        tbl.push_back(mk(0,1, 1, 9,9,12,0, 0,0,0, 3,0));  // r9 is not pending
        tbl.push_back(mk(0,1, 0, 0,0,0, 0, 0,0,0, 3,0));
        tbl.push_back(mk(0,1, 0, 0,0,0, 0, 0,0,0, 3,0));
        tbl.push_back(mk(0,1, 0, 0,0,0, 0, 0,0,0, 3,0));
        tbl.push_back(mk(0,1,19, 0,7,9, 0, 0,0,0, 3,0));
        tbl.push_back(mk(0,1, 1, 7,0,13,0, 1,0,0, 3,0));  // r7 pending: stall x3
        tbl.push_back(mk(0,1, 1, 7,0,13,0, 1,0,0, 4,0));
        tbl.push_back(mk(0,1, 1, 7,0,13,0, 1,0,0, 5,0));
        tbl.push_back(mk(0,1, 1, 7,0,13,0, 0,0,0, 6,0));
        tbl.push_back(mk(0,1,21, 1,0,0, 1, 0,1,0, 6,0));  // taken BRA
        tbl.push_back(mk(0,1, 1,13,13,14,0, 0,0,1, 6,0)); // squashed, no stall on r13
        tbl.push_back(mk(0,1,22, 0,0,0, 0, 0,0,1, 6,1));  // squashed JUMP, no redirect
        tbl.push_back(mk(0,1, 0, 0,0,0, 0, 0,0,0, 6,2));
        tbl.push_back(mk(0,1,21, 1,0,0, 0, 0,0,0, 6,2));  // not-taken BRA
        tbl.push_back(mk(0,1, 0, 0,0,0, 0, 0,0,0, 6,2));
        tbl.push_back(mk(0,1,22, 0,0,0, 0, 0,1,0, 6,2));  // JUMP with br_eq=0
        tbl.push_back(mk(0,1, 0, 0,0,0, 0, 0,0,1, 6,2));
        tbl.push_back(mk(0,1, 0, 0,0,0, 0, 0,0,1, 6,3));
        tbl.push_back(mk(0,1, 4, 1,2,0, 0, 0,0,0, 6,4));  // LOAD r2
        tbl.push_back(mk(0,1,21, 2,0,0, 1, 1,0,0, 6,4));  // BRA on r2: stall, then redirect
        tbl.push_back(mk(0,1,21, 2,0,0, 1, 1,0,0, 7,4));
        tbl.push_back(mk(0,1,21, 2,0,0, 1, 1,0,0, 8,4));
        tbl.push_back(mk(0,1,21, 2,0,0, 1, 0,1,0, 9,4));
        tbl.push_back(mk(1,0, 0, 0,0,0, 0, 0,0,1, 9,4));  // reset mid-squash
        tbl.push_back(mk(0,1, 1, 0,0,5, 0, 0,0,0, 0,0));  // ADD r5
        tbl.push_back(mk(0,0, 1, 5,0,6, 0, 0,0,0, 0,0));  // invalid: no hazard
        tbl.push_back(mk(0,0,22, 0,0,0, 0, 0,0,0, 0,0));  // invalid: no redirect
        tbl.push_back(mk(0,1, 1, 5,0,6, 0, 1,0,0, 0,0));  // WB-stage write stalls
        tbl.push_back(mk(0,1, 1, 5,0,6, 0, 0,0,0, 1,0));
        tbl.push_back(mk(0,1, 0, 0,0,0, 0, 0,0,0, 1,0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].opc, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].beq);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), tbl[i].haz, tbl[i].red, tbl[i].sq,
                      tbl[i].scnt, tbl[i].fcnt);
            @(posedge clk);
            #1;
        end

        // Saturation: seven writer/reader pairs give 21 stall cycles on a 4-bit counter.
        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        sat_stalls = 0;
        for (int k = 0; k < 7; k++) begin
            drive(0, 1, 1, 0, 0, 3, 0);
            @(posedge clk); #1;
            for (int j = 0; j < 4; j++) begin
                drive(0, 1, 1, 3, 0, 4, 0);
                if (j < 3) sat_stalls++;
                @(posedge clk); #1;
            end
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat stall_cnt", int'(stall_cnt), (sat_stalls > CMAX) ? CMAX : sat_stalls);
        chk("sat flush_cnt", int'(flush_cnt), 0);
        @(posedge clk); #1;

        // Randomized run against the reference model.
        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        model_reset();
        cur_opc = 0; cur_rs1 = 0; cur_rs2 = 0; cur_rd = 0; cur_vld = 0; cur_beq = 0;
        for (int c = 0; c < 1500; c++) begin
            bit sq, eff, haz, red;
            int depth;
            cur_rst = ($urandom_range(0, 199) == 0);
            drive(cur_rst, cur_vld, cur_opc, cur_rs1, cur_rs2, cur_rd, cur_beq);

            sq    = (m_sq_rem > 0);
            eff   = cur_vld && !sq;
            depth = WBB ? 2 : 3;
            haz   = 1'b0;
            if (eff)
                for (int i = 0; i < depth; i++)
                    if (pend[i] >= 0 &&
                        ((m_rd1(cur_opc) && cur_rs1 == pend[i]) ||
                         (m_rd2(cur_opc) && cur_rs2 == pend[i])))
                        haz = 1'b1;
            red = eff && !haz && (cur_opc == 22 || (cur_opc == 21 && cur_beq));

            @(negedge clk);
            check_all($sformatf("rnd%0d", c), haz, red, sq, m_scnt, m_fcnt);

            if (cur_rst) begin
                model_reset();
            end else begin
                pend.push_front((eff && !haz && m_writer(cur_opc)) ?
                                m_dst(cur_opc, cur_rs2, cur_rd) : -1);
                void'(pend.pop_back());
                m_sq_rem = red ? FS : (sq ? m_sq_rem - 1 : 0);
                if (haz && m_scnt < CMAX) m_scnt++;
                if (sq && m_fcnt < CMAX) m_fcnt++;
            end

            // A stalled instruction stays in RF; otherwise fetch a new one.
            if (cur_rst || !haz) begin
                cur_vld = ($urandom_range(0, 7) != 0);
                cur_opc = opc_pool[$urandom_range(0, 12)];
                cur_rs1 = $urandom_range(0, 3);
                cur_rs2 = $urandom_range(0, 3);
                cur_rd  = $urandom_range(0, 3);
                cur_beq = $urandom_range(0, 1);
            end
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
